mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the shared 1K x 16 SRAM / memory-mapped IO port.
- Requester 0 is the CPU MAR/MDR path; requester 1 is the debug/program-loader port.
- Grants one transaction at a time with round-robin fairness and drives the SRAM's mem_en, rw, addr and data.
- Waits for the SRAM's registered ready `r`, captures read data, and returns a one-cycle ack (with error on timeout) to the winner.
- Sits between the requesters and the address-control/SRAM pair; address decode for IO (03F0–03F3) stays downstream.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin two-requester arbiter and sequencer for the shared
//            1K x 16 SRAM / memory-mapped IO port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        rw0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        rw1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic        mem_r,
    input  logic [15:0] mem_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    logic          r_grant;
    logic          r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err;
    logic [15:0]   r_rdata;
    logic          r_mem_rw;
    logic [15:0]   r_mem_addr;
    logic [15:0]   r_mem_data;
    logic          w_pick1;

    // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
    assign w_pick1 = req1 & (~req0 | r_ptr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_ptr      <= 1'b0;
            r_cnt      <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 16'h0000;
            r_mem_rw   <= 1'b0;
            r_mem_addr <= 16'h0000;
            r_mem_data <= 16'h0000;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_grant    <= w_pick1;
                        r_mem_rw   <= w_pick1 ? rw1    : rw0;
                        r_mem_addr <= w_pick1 ? addr1  : addr0;
                        r_mem_data <= w_pick1 ? wdata1 : wdata0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_r) begin
                        if (!r_mem_rw) begin
                            r_rdata <= mem_out;
                        end
                        r_err   <= 1'b0;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_rdata <= 16'h0000;
                        r_err   <= 1'b1;
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr   <= ~r_grant;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The SRAM enable is a pure state decode so it can never stretch past ISSUE.
    assign mem_en   = (r_state == S_ISSUE);
    assign mem_rw   = r_mem_rw;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign err      = r_err;
    assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed stimulus for mem_arbiter with a cycle-timeline scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
    logic [15:0] addr0 = 16'h0, wdata0 = 16'h0, addr1 = 16'h0, wdata1 = 16'h0;
    logic        ack0, ack1, err, mem_en, mem_rw;
    logic [15:0] rdata, mem_addr, mem_data;
    logic        mem_r = 1'b0;
    logic [15:0] mem_out = 16'h0;

    int total = 0;
    int bad   = 0;
    bit stall = 1'b0;

    logic [15:0] sram   [1024];
    logic [15:0] shadow [1024];

    mem_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .err(err),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_r(mem_r), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = 16'(i * 3);
            shadow[i] = 16'(i * 3);
        end
        sram[0]   = 16'hF00F;
        shadow[0] = 16'hF00F;
    end

    // SRAM: ready registered one cycle after the enable; stall suppresses it.
    always @(posedge clk) begin
        mem_r   <= mem_en && !stall;
        mem_out <= 16'hDEAD;
        if (mem_en) begin
            if (mem_rw) sram[mem_addr[9:0]] <= mem_data;
            else        mem_out <= sram[mem_addr[9:0]];
        end
    end

    // Scoreboard: each granted transaction is placed on a cycle timeline
    // (enable at +1, ack at +3 or +2+TIMEOUT) and outputs are checked every cycle.
    int          k = 0, en_at = -1, ack_at = -1, free_at = 0;
    bit          g = 1'b0, ptr = 1'b0, armed = 1'b0, p_rw = 1'b0, p_to = 1'b0;
    logic [15:0] p_addr = 16'h0, p_data = 16'h0, p_rdata = 16'h0;
    logic        e_rw = 1'b0, e_err = 1'b0;
    logic [15:0] e_addr = 16'h0, e_data = 16'h0, e_rdata = 16'h0;

    initial begin
        forever begin
            @(negedge clk);
            if (k == en_at) begin
                if (p_rw) shadow[p_addr[9:0]] = p_data;
                else      p_rdata = shadow[p_addr[9:0]];
            end
            if (k == ack_at) begin
                e_err = p_to;
                if (p_to)       e_rdata = 16'h0000;
                else if (!p_rw) e_rdata = p_rdata;
                ptr = ~g;
            end
            if (armed) begin
                chk("m_ack0",   {31'd0, ack0},   {31'd0, (k == ack_at) && !g});
                chk("m_ack1",   {31'd0, ack1},   {31'd0, (k == ack_at) && g});
                chk("m_mem_en", {31'd0, mem_en}, {31'd0, k == en_at});
                chk("m_mem_rw", {31'd0, mem_rw}, {31'd0, e_rw});
                chk("m_mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
                chk("m_mem_data", {16'd0, mem_data}, {16'd0, e_data});
                chk("m_err",    {31'd0, err},    {31'd0, e_err});
                chk("m_rdata",  {16'd0, rdata},  {16'd0, e_rdata});
            end
            if (rst) begin
                en_at = -1; ack_at = -1; free_at = k + 1; ptr = 1'b0;
                e_rw = 1'b0; e_addr = 16'h0; e_data = 16'h0; e_err = 1'b0; e_rdata = 16'h0;
                armed = 1'b1;
            end else if (k >= free_at && (req0 || req1)) begin
                g       = req1 && (!req0 || ptr);
                p_rw    = g ? rw1 : rw0;
                p_addr  = g ? addr1 : addr0;
                p_data  = g ? wdata1 : wdata0;
                p_to    = stall;
                e_rw    = p_rw; e_addr = p_addr; e_data = p_data;
                en_at   = k + 1;
                ack_at  = p_to ? k + 2 + TIMEOUT : k + 3;
                free_at = ack_at + 1;
            end
            k++;
        end
    end

    int          got_port, got_lat, en_cnt, en_idx;
    logic [15:0] en_addr, en_data;

    task automatic wait_ack();
        got_port = -1; got_lat = -1; en_cnt = 0; en_idx = -1;
        en_addr = 16'h0; en_data = 16'h0;
        for (int i = 0; i < 64 && got_port < 0; i++) begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                en_cnt++;
                if (en_idx < 0) begin
                    en_idx = i; en_addr = mem_addr; en_data = mem_data;
                end
            end
            if (ack0 === 1'b1)      begin got_port = 0; got_lat = i; end
            else if (ack1 === 1'b1) begin got_port = 1; got_lat = i; end
        end
        chk("ack_seen", {31'd0, got_port >= 0}, 32'd1);
    endtask

    task automatic run_txn(input int port, input logic rw, input logic [15:0] a,
                           input logic [15:0] d);
        @(posedge clk); #1;
        if (port == 0) begin req0 = 1'b1; rw0 = rw; addr0 = a; wdata0 = d; end
        else           begin req1 = 1'b1; rw1 = rw; addr1 = a; wdata1 = d; end
        wait_ack();
        @(posedge clk); #1;
        if (port == 0) req0 = 1'b0;
        else           req1 = 1'b0;
    endtask

    int          order[$];
    int          at[$];
    logic [15:0] rd_first;
    int          cnt;

    initial begin
        // Contention from reset: both requesters high continuously.
        rst = 1'b1;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0000;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0005;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rd_first = 16'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("both_ack", {31'd0, ack0 & ack1}, 32'd0);
            if (ack0 === 1'b1) begin
                if (order.size() == 0) rd_first = rdata;
                order.push_back(0); at.push_back(i);
            end
            if (ack1 === 1'b1) begin
                order.push_back(1); at.push_back(i);
            end
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        chk("cont_count", order.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < order.size()) begin
                chk("cont_order", order[i], i % 2);
                chk("cont_cycle", at[i], 3 + 4 * i);
            end
        end
        chk("read_reset_addr0", {16'd0, rd_first}, 32'hF00F);

        // Single CPU write.
        run_txn(0, 1'b1, 16'h0010, 16'hBEEF);
        chk("wr_port", got_port, 0);
        chk("wr_latency", got_lat, 3);
        chk("wr_en_cycle", en_idx, 1);
        chk("wr_en_count", en_cnt, 1);
        chk("wr_en_addr", {16'd0, en_addr}, 32'h0010);
        chk("wr_en_data", {16'd0, en_data}, 32'hBEEF);
        chk("wr_err", {31'd0, err}, 32'd0);

        // CPU read back.
        run_txn(0, 1'b0, 16'h0010, 16'h0000);
        chk("rd_latency", got_lat, 3);
        chk("rd_data", {16'd0, rdata}, 32'hBEEF);

        // Timeout on the debug port, then a normal read clears err.
        stall = 1'b1;
        run_txn(1, 1'b0, 16'h0020, 16'h0000);
        stall = 1'b0;
        chk("to_port", got_port, 1);
        chk("to_latency", got_lat, 2 + TIMEOUT);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_rdata", {16'd0, rdata}, 32'h0000);
        run_txn(1, 1'b0, 16'h0010, 16'h0000);
        chk("post_to_err", {31'd0, err}, 32'd0);
        chk("post_to_rdata", {16'd0, rdata}, 32'hBEEF);

        // Reset mid-WAIT after leaving the pointer at requester 1.
        run_txn(0, 1'b1, 16'h0030, 16'h1234);
        stall = 1'b1;
        @(posedge clk); #1 req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0030;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1; req0 = 1'b0;
        @(posedge clk); #1 rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'h0000);
        chk("rst_rdata", {16'd0, rdata}, 32'h0000);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            cnt += int'(ack0) + int'(ack1);
        end
        chk("rst_no_ack", cnt, 0);

        @(posedge clk); #1;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0030;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0010;
        wait_ack();
        chk("ptr_rst_first", got_port, 0);
        chk("ptr_rst_rdata0", {16'd0, rdata}, 32'h1234);
        @(posedge clk); #1 req0 = 1'b0;
        wait_ack();
        chk("ptr_rst_second", got_port, 1);
        chk("ptr_rst_lat", got_lat, 3);
        chk("ptr_rst_rdata1", {16'd0, rdata}, 32'hBEEF);
        @(posedge clk); #1 req1 = 1'b0;

        // Debug write whose req drops during ISSUE.
        @(posedge clk); #1 req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h5555;
        @(posedge clk); #1 req1 = 1'b0;
        wait_ack();
        chk("drop_port", got_port, 1);
        chk("drop_latency", got_lat, 2);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            cnt += int'(mem_en) + int'(ack0) + int'(ack1);
        end
        chk("drop_idle", cnt, 0);
        run_txn(0, 1'b0, 16'h0040, 16'h0000);
        chk("drop_readback", {16'd0, rdata}, 32'h5555);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
